refclk100_reset_sequencer: RTL

//   Power-on/recovery reset sequencer clocked by the 100 MHz reference derived from the 300 MHz board refclk.

---
 rtl/refclk100_reset_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/refclk100_reset_sequencer.sv
// Reset sequencer on the 100 MHz reference clock: holds the GT in reset,
// releases it, waits for a stable synchronized lock, then releases the
// system reset. Retries on lock timeout, re-sequences on lock loss and
// reports done/fail/status. Every output is a registered copy of the
// sequencer's internal state, so all status fields move together.
module refclk100_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 100,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned LOCK_TIMEOUT  = 10000000,
  parameter int unsigned NUM_RETRIES   = 3
) (
  input  logic       refclk100,
  input  logic       refclk100_rst,
  input  logic       ext_rst_req,
  input  logic       gt_lock,
  output logic       gt_rst,
  output logic       sys_rst,
  output logic       seq_done,
  output logic       seq_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int unsigned SW = (STABLE_CYCLES > 0) ? $clog2(STABLE_CYCLES + 1) : 1;

  localparam logic [TW-1:0] HOLD_LAST    = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(NUM_RETRIES);

  typedef enum logic [2:0] {
    ST_HOLD_GT   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_HOLD_SYS  = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   stable_q, stable_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            lock_meta_q, lock_meta_d;
  logic            lock_s_q, lock_s_d;

  logic            gt_rst_q, gt_rst_d;
  logic            sys_rst_q, sys_rst_d;
  logic            seq_done_q, seq_done_d;
  logic            seq_fail_q, seq_fail_d;
  logic [3:0]      retry_out_q, retry_out_d;
  logic [7:0]      loss_out_q, loss_out_d;
  logic [2:0]      state_out_q, state_out_d;

  // Two-flop synchronizer for the asynchronous lock input.
  always_comb begin
    lock_meta_d = gt_lock;
    lock_s_d    = lock_meta_q;
  end

  // Sequencer next-state: request overrides everything, then per-state rules.
  // The stable counter saturates one below its target because reaching the
  // target is itself the exit condition, so it never needs the full value.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    if (ext_rst_req) begin
      state_d  = ST_HOLD_GT;
      timer_d  = '0;
      stable_d = '0;
      retry_d  = '0;
    end else begin
      case (state_q)
        ST_HOLD_GT: begin
          if (timer_q == HOLD_LAST) begin
            state_d  = ST_WAIT_LOCK;
            timer_d  = '0;
            stable_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q && (stable_q == STABLE_LAST)) begin
            state_d  = ST_HOLD_SYS;
            timer_d  = '0;
            stable_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            timer_d  = '0;
            stable_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_HOLD_GT;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            timer_d  = timer_q + 1'b1;
            stable_d = lock_s_q ? (stable_q + 1'b1) : '0;
          end
        end
        ST_HOLD_SYS: begin
          if (!lock_s_q) begin
            state_d = ST_HOLD_GT;
            timer_d = '0;
          end else if (timer_q == HOLD_LAST) begin
            state_d = ST_RUN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d = ST_HOLD_GT;
            timer_d = '0;
            retry_d = '0;
            loss_d  = (loss_q != 8'hFF) ? (loss_q + 8'd1) : loss_q;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d  = ST_HOLD_GT;
          timer_d  = '0;
          stable_d = '0;
        end
      endcase
    end
  end

  // Output decode from the current state register; unknown encodings hold both resets.
  always_comb begin
    gt_rst_d    = 1'b1;
    sys_rst_d   = 1'b1;
    seq_done_d  = 1'b0;
    seq_fail_d  = 1'b0;
    retry_out_d = retry_q;
    loss_out_d  = loss_q;
    state_out_d = state_q;
    case (state_q)
      ST_WAIT_LOCK, ST_HOLD_SYS: gt_rst_d = 1'b0;
      ST_RUN: begin
        gt_rst_d   = 1'b0;
        sys_rst_d  = 1'b0;
        seq_done_d = 1'b1;
      end
      ST_FAIL: seq_fail_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters, synchronizer and output registers.
  always_ff @(posedge refclk100) begin
    if (refclk100_rst) begin
      state_q     <= ST_HOLD_GT;
      timer_q     <= '0;
      stable_q    <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      gt_rst_q    <= 1'b1;
      sys_rst_q   <= 1'b1;
      seq_done_q  <= 1'b0;
      seq_fail_q  <= 1'b0;
      retry_out_q <= '0;
      loss_out_q  <= '0;
      state_out_q <= ST_HOLD_GT;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stable_q    <= stable_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      gt_rst_q    <= gt_rst_d;
      sys_rst_q   <= sys_rst_d;
      seq_done_q  <= seq_done_d;
      seq_fail_q  <= seq_fail_d;
      retry_out_q <= retry_out_d;
      loss_out_q  <= loss_out_d;
      state_out_q <= state_out_d;
    end
  end

  assign gt_rst        = gt_rst_q;
  assign sys_rst       = sys_rst_q;
  assign seq_done      = seq_done_q;
  assign seq_fail      = seq_fail_q;
  assign retry_cnt     = retry_out_q;
  assign lock_loss_cnt = loss_out_q;
  assign state         = state_out_q;

endmodule
